usr_burst: RTL and testbench
============================

USR_BURST -- requirements
Module: usr_burst

Interface
REQ-001 Parameter: WIDTH, default 8, register width; legal range 2..64.
REQ-002 Parameter: CNT_W, default $clog2(WIDTH+1), width of the burst length field.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 sel  input  3  mode: 000 HOLD, 001 SHL, 010 SHR, 011 LOAD, 100 ROL, 101 ROR, 110 ASR, 111 BURST.
REQ-006 pi  input  WIDTH  parallel load data.
REQ-007 si  input  1  serial input bit for SHL, SHR and BURST.
REQ-008 dir  input  1  burst direction (0 right, 1 left), sampled at burst start only.
REQ-009 len  input  CNT_W  burst shift count, sampled at burst start only.
REQ-010 po  output  WIDTH  register contents.
REQ-011 so  output  1  serial output bit.
REQ-012 busy  output  1  high while the block is in the RUN state.
REQ-013 done  output  1  one-cycle pulse on burst completion.

Function
REQ-014 All shift and rotate modes shall operate on the current po; pi is used only by LOAD.
REQ-015 In IDLE, one clock edge shall apply the selected mode:
- HOLD: po unchanged.
- SHL: {po[W-2:0],si}.
- SHR: {si,po[W-1:1]}.
- LOAD: pi.
- ROL: {po[W-2:0],po[W-1]}.
- ROR: {po[0],po[W-1:1]}.
- ASR: {po[W-1],po[W-1:1]}, si ignored.
REQ-016 The state machine shall have two states, IDLE and RUN, with a remaining-count register cnt of width CNT_W.
REQ-017 The effective burst length shall be L = min(len, WIDTH).
REQ-018 sel=BURST in IDLE with L=0: po unchanged, done=1 on the next cycle, state remains IDLE.
REQ-019 sel=BURST in IDLE with L>=1, at that edge:
- po shifts once in direction dir, filling with si (dir=1 as SHL, dir=0 as SHR).
- dir is latched.
- cnt <= L-1.
- next state is RUN if L>1, otherwise IDLE with done=1.
REQ-020 In RUN, each edge:
- po shifts once in the latched direction, filling with si.
- cnt decrements.
- when cnt==1 at the edge: state goes to IDLE and done=1 for exactly one cycle.
REQ-021 A burst of length L shall perform exactly L shifts, with busy high for L-1 cycles and done high in the cycle after the L-th shift.
REQ-022 In RUN, sel, pi, len and dir shall be ignored; si shall be sampled every cycle.
REQ-023 done shall be 0 in every cycle other than those defined in REQ-018 to REQ-021.
REQ-024 so shall be combinational:
- po[W-1] when the effective direction is left (RUN with latched dir=1, or IDLE with sel SHL/ROL);
- po[0] otherwise.
REQ-025 A BURST may be issued in the cycle immediately after done, and shall start normally.

Reset
REQ-026 When rst=0 at a clock edge: po=0, cnt=0, state=IDLE, busy=0, done=0, latched dir=0.
REQ-027 Reset shall take priority over every mode, including a burst in progress; an aborted burst shall never produce done.
REQ-028 After reset release, the first edge with rst=1 shall obey sel normally.

Structure
REQ-029 Package usr_pkg shall hold the sel mode encodings and the IDLE/RUN state type.
REQ-030 Sub-module usr_shift_core shall be purely combinational and compute next po from (po, pi, si, mode, direction); usr_burst shall hold all registers and the FSM.

Verification (WIDTH=8)
REQ-031 Reset: rst=0 for 2 edges with sel=LOAD, pi=8'hFF -> po=8'h00, busy=0, done=0, so=0.
REQ-032 Basic modes:
- LOAD 8'hA5 -> po=8'hA5.
- SHL with si=1 -> po=8'h4B, so=0.
- ROR -> po=8'hA5.
- ASR from 8'h96 -> 8'hCB, then -> 8'hE5.
REQ-033 Burst: po=8'hF0, BURST with len=3, dir=0, si=0, sel driven to LOAD during busy:
- po sequence 78, 3C, 1E;
- busy=1 for 2 cycles;
- done=1 for 1 cycle;
- LOAD ignored.
REQ-034 Length boundaries:
- BURST len=0 -> po unchanged, done=1 for one cycle, busy=0.
- BURST len=12, dir=1, si=1 from 8'h00 -> exactly 8 shifts, po=8'hFF, busy=1 for 7 cycles.
REQ-035 Mid-burst reset: rst=0 during RUN -> next edge po=0, busy=0, done stays 0.
REQ-036 Back-to-back: BURST re-issued in the cycle of done -> second burst completes with correct count and a second done pulse.

Source files
------------

// File: rtl/usr_pkg.sv
// -----------------------------------------------------------------------------
// usr_pkg
// Shared definitions for the usr_burst shift register:
//   sel_e   - 3-bit operating mode carried on the sel input
//   state_e - burst sequencer state (IDLE / RUN)
// -----------------------------------------------------------------------------
package usr_pkg;

    typedef enum logic [2:0] {
        SEL_HOLD  = 3'b000,
        SEL_SHL   = 3'b001,
        SEL_SHR   = 3'b010,
        SEL_LOAD  = 3'b011,
        SEL_ROL   = 3'b100,
        SEL_ROR   = 3'b101,
        SEL_ASR   = 3'b110,
        SEL_BURST = 3'b111
    } sel_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/usr_burst_if.sv
// -----------------------------------------------------------------------------
// usr_burst_if
// Control/data bundle of the usr_burst shift register.
//   master : drives sel, pi, si, dir, len; observes po, so, busy, done
//   slave  : the shift register itself
// -----------------------------------------------------------------------------
interface usr_burst_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
);
    logic [2:0]       sel;   // mode, encoded as usr_pkg::sel_e
    logic [WIDTH-1:0] pi;    // parallel load data
    logic             si;    // serial fill bit
    logic             dir;   // burst direction: 1 left, 0 right
    logic [CNT_W-1:0] len;   // requested burst length
    logic [WIDTH-1:0] po;    // register contents
    logic             so;    // serial output bit
    logic             busy;  // burst in progress
    logic             done;  // one-cycle burst completion pulse

    modport master (
        output sel, pi, si, dir, len,
        input  po, so, busy, done
    );

    modport slave (
        input  sel, pi, si, dir, len,
        output po, so, busy, done
    );
endinterface

// File: rtl/usr_shift_core.sv
// -----------------------------------------------------------------------------
// usr_shift_core
// Purely combinational next-value datapath for the shift register.
//   i_po      current register contents
//   i_pi      parallel load data (LOAD only)
//   i_si      serial fill bit (SHL, SHR, BURST)
//   i_mode    operation to apply
//   i_dir     BURST direction: 1 behaves as SHL, 0 as SHR
//   o_po_nxt  register value after the operation
// -----------------------------------------------------------------------------
module usr_shift_core
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_po,
    input  logic [WIDTH-1:0] i_pi,
    input  logic             i_si,
    input  sel_e             i_mode,
    input  logic             i_dir,
    output logic [WIDTH-1:0] o_po_nxt
);

    always_comb begin
        // NOTE: assign a default before the case so no path leaves the output unassigned (latch).
        o_po_nxt = i_po;
        case (i_mode)
            SEL_HOLD:  o_po_nxt = i_po;
            SEL_SHL:   o_po_nxt = {i_po[WIDTH-2:0], i_si};
            SEL_SHR:   o_po_nxt = {i_si, i_po[WIDTH-1:1]};
            SEL_LOAD:  o_po_nxt = i_pi;
            SEL_ROL:   o_po_nxt = {i_po[WIDTH-2:0], i_po[WIDTH-1]};
            SEL_ROR:   o_po_nxt = {i_po[0], i_po[WIDTH-1:1]};
            SEL_ASR:   o_po_nxt = {i_po[WIDTH-1], i_po[WIDTH-1:1]};
            SEL_BURST: o_po_nxt = i_dir ? {i_po[WIDTH-2:0], i_si}
                                        : {i_si, i_po[WIDTH-1:1]};
        endcase
    end

endmodule

// File: rtl/usr_burst.sv
// -----------------------------------------------------------------------------
// usr_burst
// Universal shift register with a multi-cycle burst-shift mode.
//   clk  sole clock, rising edge
//   rst  synchronous reset, active low
//   bus  usr_burst_if.slave: sel/pi/si/dir/len in, po/so/busy/done out
// In IDLE every edge applies the selected mode once. BURST shifts
// min(len, WIDTH) times in the direction sampled at the start edge; the
// remaining shifts run in RUN, where sel/pi/len/dir are ignored.
// -----------------------------------------------------------------------------
module usr_burst
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic        clk,
    input  logic        rst,
    usr_burst_if.slave  bus
);

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dir;
    logic [WIDTH-1:0] r_po;
    logic             r_done;

    state_e           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_dir_nxt;
    logic [WIDTH-1:0] w_po_nxt;
    logic             w_done_nxt;

    sel_e             w_sel;
    sel_e             w_core_mode;
    logic             w_core_dir;
    logic [WIDTH-1:0] w_core_po;
    logic [CNT_W-1:0] w_len_eff;
    logic             w_left;

    assign w_sel     = sel_e'(bus.sel);
    assign w_len_eff = (bus.len > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : bus.len;

    // While running, the datapath is forced to burst with the latched direction.
    assign w_core_mode = (r_state == ST_RUN) ? SEL_BURST : w_sel;
    assign w_core_dir  = (r_state == ST_RUN) ? r_dir     : bus.dir;

    usr_shift_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_po     (r_po),
        .i_pi     (bus.pi),
        .i_si     (bus.si),
        .i_mode   (w_core_mode),
        .i_dir    (w_core_dir),
        .o_po_nxt (w_core_po)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dir_nxt   = r_dir;
        w_po_nxt    = r_po;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_sel == SEL_BURST) begin
                    if (w_len_eff == '0) begin
                        // Zero-length burst: no shift, completion reported at once.
                        w_done_nxt = 1'b1;
                    end else begin
                        w_po_nxt  = w_core_po;
                        w_dir_nxt = bus.dir;
                        w_cnt_nxt = w_len_eff - CNT_W'(1);
                        if (w_len_eff == CNT_W'(1)) begin
                            w_done_nxt = 1'b1;
                        end else begin
                            w_state_nxt = ST_RUN;
                        end
                    end
                end else begin
                    w_po_nxt = w_core_po;
                end
            end
            ST_RUN: begin
                w_po_nxt  = w_core_po;
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
        endcase
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
            r_po    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dir   <= w_dir_nxt;
            r_po    <= w_po_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Serial output follows the end the data is currently moving towards.
    assign w_left = (r_state == ST_RUN) ? r_dir
                                        : ((w_sel == SEL_SHL) || (w_sel == SEL_ROL));

    assign bus.po   = r_po;
    assign bus.so   = w_left ? r_po[WIDTH-1] : r_po[0];
    assign bus.busy = (r_state == ST_RUN);
    assign bus.done = r_done;

endmodule

// File: tb/tb_usr_burst.sv
// -----------------------------------------------------------------------------
// tb_usr_burst
// Directed bench for usr_burst (WIDTH=8). A behavioural model tracks the
// register value and outstanding burst shifts; a compare process checks
// po/busy/done/so against it after every edge, and the stimulus adds
// hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_usr_burst;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    usr_burst_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    usr_burst #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [7:0] po;
        logic [7:0] left;   // burst shifts still to be performed
        logic       dir;
        logic       done;
    } mdl_t;

    mdl_t m = '0;

    function automatic logic [7:0] shift1(input logic [7:0] v, input logic to_left, input logic fill);
        return to_left ? ((v << 1) | {7'b0, fill}) : ((v >> 1) | {fill, 7'b0});
    endfunction

    function automatic mdl_t model_step(input mdl_t s, input logic rst_v, input logic [2:0] sel_v,
                                        input logic [7:0] pi_v, input logic si_v,
                                        input logic dir_v, input logic [CW-1:0] len_v);
        mdl_t n;
        int   l;
        n      = s;
        n.done = 1'b0;
        if (!rst_v) return '0;
        if (s.left != 0) begin
            n.po   = shift1(s.po, s.dir, si_v);
            n.left = s.left - 8'd1;
            n.done = (n.left == 0);
            return n;
        end
        case (sel_v)
            3'd1: n.po = shift1(s.po, 1'b1, si_v);
            3'd2: n.po = shift1(s.po, 1'b0, si_v);
            3'd3: n.po = pi_v;
            3'd4: n.po = (s.po << 1) | (s.po >> 7);
            3'd5: n.po = (s.po >> 1) | (s.po << 7);
            3'd6: n.po = (s.po >> 1) | (s.po & 8'h80);
            3'd7: begin
                l = (int'(len_v) > W) ? W : int'(len_v);
                if (l == 0) begin
                    n.done = 1'b1;
                end else begin
                    n.dir  = dir_v;
                    n.po   = shift1(s.po, dir_v, si_v);
                    n.left = 8'(l - 1);
                    n.done = (l == 1);
                end
            end
            default: ;
        endcase
        return n;
    endfunction

    always @(posedge clk)
        m <= model_step(m, rst, bus.sel, bus.pi, bus.si, bus.dir, bus.len);

    // Compare every cycle, away from the edge, while inputs are still stable.
    always @(posedge clk) begin
        logic exp_left;
        #1;
        exp_left = (m.left != 0) ? m.dir : (bus.sel == 3'd1 || bus.sel == 3'd4);
        check("cmp_po",   bus.po,   m.po);
        check("cmp_busy", bus.busy, (m.left != 0));
        check("cmp_done", bus.done, m.done);
        check("cmp_so",   bus.so,   exp_left ? m.po[7] : m.po[0]);
    end

    // ---------------- stimulus helpers ----------------
    task automatic op(input logic [2:0] s, input logic [7:0] p, input logic serial);
        bus.sel = s;
        bus.pi  = p;
        bus.si  = serial;
        @(negedge clk);
    endtask

    // Issue a burst, keep sel=LOAD while busy (must be ignored), observe until done.
    // With chain set, return in the done cycle so the caller can re-issue at once.
    task automatic burst(input logic [CW-1:0] l, input logic d, input logic serial, input bit chain,
                         output int busy_n, output int done_n,
                         output logic [7:0] first_po, output logic [7:0] last_po);
        bit fin;
        fin     = 1'b0;
        busy_n  = 0;
        done_n  = 0;
        bus.sel = 3'd7;
        bus.len = l;
        bus.dir = d;
        bus.si  = serial;
        @(negedge clk);
        first_po = bus.po;
        last_po  = bus.po;
        for (int i = 0; i < 24; i++) begin
            last_po = bus.po;
            busy_n += int'(bus.busy);
            done_n += int'(bus.done);
            if (bus.done) begin
                fin = 1'b1;
                break;
            end
            if (bus.busy) begin
                bus.sel = 3'd3;
                bus.pi  = 8'h55;
            end else begin
                bus.sel = 3'd0;
            end
            @(negedge clk);
        end
        check("burst_done_seen", fin, 1'b1);
        if (fin && !chain) begin
            bus.sel = 3'd0;
            @(negedge clk);
            busy_n += int'(bus.busy);
            done_n += int'(bus.done);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int         bn, dn, cnt;
        logic [7:0] fp, lp;

        // Reset: two edges with LOAD FF pending.
        rst = 1'b0; bus.sel = 3'd3; bus.pi = 8'hFF; bus.si = 1'b0; bus.dir = 1'b0; bus.len = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_po",   bus.po,   8'h00);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_so",   bus.so,   1'b0);
        rst = 1'b1;

        // Basic modes.
        op(3'd3, 8'hA5, 1'b0); check("load_a5", bus.po, 8'hA5);
        op(3'd1, 8'h00, 1'b1); check("shl_po",  bus.po, 8'h4B);
                               check("shl_so",  bus.so, 1'b0);
        op(3'd5, 8'h00, 1'b0); check("ror_po",  bus.po, 8'hA5);
        op(3'd3, 8'h96, 1'b0); check("load_96", bus.po, 8'h96);
        op(3'd6, 8'h00, 1'b1); check("asr_1",   bus.po, 8'hCB);
        op(3'd6, 8'h00, 1'b0); check("asr_2",   bus.po, 8'hE5);
        op(3'd0, 8'hFF, 1'b1); check("hold",    bus.po, 8'hE5);
        op(3'd2, 8'h00, 1'b0); check("shr",     bus.po, 8'h72);
        op(3'd4, 8'h00, 1'b0); check("rol_po",  bus.po, 8'hE4);
                               check("rol_so",  bus.so, 1'b1);
                               check("model_pin_e4", m.po, 8'hE4);

        // Burst of 3 to the right, LOAD requested while busy.
        op(3'd3, 8'hF0, 1'b0);
        burst(4'd3, 1'b0, 1'b0, 1'b0, bn, dn, fp, lp);
        check("b3_first", fp, 8'h78);
        check("b3_last",  lp, 8'h1E);
        check("b3_busy",  bn, 2);
        check("b3_done",  dn, 1);
        check("b3_hold",  bus.po, 8'h1E);

        // Zero length: no shift, single done pulse.
        burst(4'd0, 1'b1, 1'b1, 1'b0, bn, dn, fp, lp);
        check("b0_po",   lp, 8'h1E);
        check("b0_busy", bn, 0);
        check("b0_done", dn, 1);

        // Length one: single shift, never busy.
        op(3'd3, 8'h00, 1'b0);
        burst(4'd1, 1'b1, 1'b1, 1'b0, bn, dn, fp, lp);
        check("b1_po",   lp, 8'h01);
        check("b1_busy", bn, 0);
        check("b1_done", dn, 1);

        // Over-long request clamps to WIDTH shifts.
        op(3'd3, 8'h00, 1'b0);
        burst(4'd12, 1'b1, 1'b1, 1'b0, bn, dn, fp, lp);
        check("b12_first", fp, 8'h01);
        check("b12_po",    lp, 8'hFF);
        check("b12_busy",  bn, 7);
        check("b12_done",  dn, 1);
        check("model_pin_ff", m.po, 8'hFF);

        // Back-to-back: second burst issued in the done cycle of the first.
        op(3'd3, 8'h00, 1'b0);
        burst(4'd2, 1'b1, 1'b1, 1'b1, bn, dn, fp, lp);
        check("bb1_po",   lp, 8'h03);
        check("bb1_busy", bn, 1);
        check("bb1_done", dn, 1);
        burst(4'd3, 1'b0, 1'b1, 1'b0, bn, dn, fp, lp);
        check("bb2_first", fp, 8'h81);
        check("bb2_po",    lp, 8'hE0);
        check("bb2_busy",  bn, 2);
        check("bb2_done",  dn, 1);

        // Reset in the middle of a burst.
        op(3'd3, 8'h0F, 1'b0);
        bus.len = 4'd5; bus.dir = 1'b1;
        op(3'd7, 8'h00, 1'b0); check("mr_po1", bus.po, 8'h1E);
                               check("mr_busy1", bus.busy, 1'b1);
        op(3'd0, 8'h00, 1'b0); check("mr_po2", bus.po, 8'h3C);
        rst = 1'b0;
        @(negedge clk);
        check("mr_po",   bus.po,   8'h00);
        check("mr_busy", bus.busy, 1'b0);
        check("mr_done", bus.done, 1'b0);
        rst = 1'b1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cnt += int'(bus.done) + int'(bus.busy);
        end
        check("mr_no_done", cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
